// File: rtl/interp_pkg.sv
// Shared definitions for the rate-conversion chain (upsampler, filter,
// downsampler): sample width, decimator mode codes, saturation limits and
// a constant-evaluable ceil(log2) helper used to size accumulators.
package interp_pkg;

  localparam int SAMPLE_W = 32;

  localparam int MODE_PICK = 0;
  localparam int MODE_ACC  = 1;

  localparam logic [SAMPLE_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [SAMPLE_W-1:0] SAT_MIN = 32'h8000_0000;

  // ceil(log2(value)); clog2(1) = 0 so an R=1 accumulator is exactly SAMPLE_W wide.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/downsampler_sat_shift.sv
// sat_shift: combinational arithmetic right shift of an AW-bit signed value
// followed by saturation to a 32-bit signed sample.
// Ports:
//   x  in  AW  signed wide value (e.g. an accumulator sum)
//   y  out 32  shifted value clamped to [SAT_MIN, SAT_MAX]
module sat_shift
  import interp_pkg::*;
#(
  parameter int AW    = 33,
  parameter int SHIFT = 0
) (
  input  logic signed [AW-1:0]       x,
  output logic        [SAMPLE_W-1:0] y
);

  if (AW < SAMPLE_W) begin : g_param_check
    $error("sat_shift: AW=%0d must be at least %0d", AW, SAMPLE_W);
  end

  logic signed [AW-1:0]         shifted;
  logic        [AW-SAMPLE_W:0]  top;

  assign shifted = x >>> SHIFT;
  // The value fits in 32 bits exactly when every bit from the 32-bit sign
  // position upwards agrees.
  assign top = shifted[AW-1:SAMPLE_W-1];

  always_comb begin
    y = shifted[SAMPLE_W-1:0];
    if (!((&top) || (~|top))) y = shifted[AW-1] ? SAT_MIN : SAT_MAX;
  end

endmodule

// File: rtl/downsampler.sv
// downsampler: decimate a 32-bit signed valid/ready stream by R.
//   MODE_PICK: forward only the sample at phase PHASE of each group of R.
//   MODE_ACC : sum each group of R, arithmetic shift by SHIFT, saturate.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clr        synchronous flush of phase counter and accumulator
//   d_in       signed input sample, qualified by in_valid
//   in_valid   input sample valid
//   in_ready   block accepts d_in this cycle
//   d_out      registered decimated sample, qualified by out_valid
//   out_valid  registered output valid
//   out_ready  downstream accepts d_out
module downsampler
  import interp_pkg::*;
#(
  parameter int R     = 2,
  parameter int PHASE = 0,
  parameter int MODE  = 0,
  parameter int SHIFT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [SAMPLE_W-1:0] d_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [SAMPLE_W-1:0] d_out,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int AW = SAMPLE_W + clog2(R);
  localparam logic [7:0] LAST    = 8'(R - 1);
  localparam logic [7:0] PHASE_C = 8'(PHASE);

  if (R < 1 || R > 255 || PHASE < 0 || PHASE >= R || SHIFT < 0 ||
      SHIFT > clog2(R) || (MODE != MODE_PICK && MODE != MODE_ACC)) begin : g_param_check
    $error("downsampler: illegal parameters R=%0d PHASE=%0d MODE=%0d SHIFT=%0d",
           R, PHASE, MODE, SHIFT);
  end

  logic        [7:0]          cnt;
  logic signed [AW-1:0]       acc;
  logic signed [AW-1:0]       sum;
  logic        [SAMPLE_W-1:0] acc_out;
  logic                       accept;
  logic                       at_last;
  logic                       load;
  logic        [SAMPLE_W-1:0] load_val;

  // Stall even samples that would be discarded: keeps phase alignment
  // strictly tied to the output handshake.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign at_last  = (cnt == LAST);
  assign sum      = acc + AW'($signed(d_in));

  sat_shift #(
    .AW   (AW),
    .SHIFT(SHIFT)
  ) u_sat_shift (
    .x(sum),
    .y(acc_out)
  );

  // A flush on the same cycle as an accept swallows the sample.
  always_comb begin
    load     = 1'b0;
    load_val = d_in;
    if (accept && !clr) begin
      if (MODE == MODE_ACC) begin
        load     = at_last;
        load_val = acc_out;
      end else begin
        load = (cnt == PHASE_C);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      acc       <= '0;
      d_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
        acc <= '0;
      end else if (accept) begin
        cnt <= at_last ? 8'd0 : cnt + 8'd1;
        if (MODE == MODE_ACC) acc <= at_last ? '0 : sum;
      end

      // A load while the old output is being consumed replaces it without a bubble.
      if (load) begin
        d_out     <= load_val;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_downsampler.sv
module tb_downsampler;

  logic        clk;
  logic        rst;
  logic [31:0] din  [7];
  logic        iv   [7];
  logic        ordy [7];
  logic        clr_s[7];
  logic [31:0] dout [7];
  logic        ov   [7];
  logic        ir   [7];

  int n_checks;
  int n_fail;

  // 0: pick R2 P0 | 1: pick R3 P2 | 2: acc R4 S2 | 3: acc R2 S0
  // 4: pick R4 P3 | 5: pick R1    | 6: acc R1 S0
  downsampler #(.R(2), .PHASE(0), .MODE(0), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr_s[0]), .d_in(din[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .d_out(dout[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  downsampler #(.R(3), .PHASE(2), .MODE(0), .SHIFT(0)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr_s[1]), .d_in(din[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .d_out(dout[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  downsampler #(.R(4), .PHASE(0), .MODE(1), .SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr_s[2]), .d_in(din[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .d_out(dout[2]), .out_valid(ov[2]), .out_ready(ordy[2]));
  downsampler #(.R(2), .PHASE(0), .MODE(1), .SHIFT(0)) u_dut3 (
    .clk(clk), .rst(rst), .clr(clr_s[3]), .d_in(din[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .d_out(dout[3]), .out_valid(ov[3]), .out_ready(ordy[3]));
  downsampler #(.R(4), .PHASE(3), .MODE(0), .SHIFT(0)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr_s[4]), .d_in(din[4]), .in_valid(iv[4]), .in_ready(ir[4]),
    .d_out(dout[4]), .out_valid(ov[4]), .out_ready(ordy[4]));
  downsampler #(.R(1), .PHASE(0), .MODE(0), .SHIFT(0)) u_dut5 (
    .clk(clk), .rst(rst), .clr(clr_s[5]), .d_in(din[5]), .in_valid(iv[5]), .in_ready(ir[5]),
    .d_out(dout[5]), .out_valid(ov[5]), .out_ready(ordy[5]));
  downsampler #(.R(1), .PHASE(0), .MODE(1), .SHIFT(0)) u_dut6 (
    .clk(clk), .rst(rst), .clr(clr_s[6]), .d_in(din[6]), .in_valid(iv[6]), .in_ready(ir[6]),
    .d_out(dout[6]), .out_valid(ov[6]), .out_ready(ordy[6]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Streams vals[0..n-1] into instance k and records every output handed
  // downstream. With toggle set, out_ready alternates each cycle.
  task automatic drive_stream(input int k, input logic [31:0] vals[16], input int n,
                              input bit toggle, output logic [31:0] got[16], output int ng);
    int idx;
    bit ph;
    idx = 0; ng = 0; ph = 1'b0;
    for (int j = 0; j < 16; j++) got[j] = '0;
    for (int c = 0; c < 4 * n + 20; c++) begin
      @(negedge clk);
      ordy[k] = toggle ? ph : 1'b1;
      ph      = !ph;
      iv[k]   = (idx < n);
      din[k]  = (idx < n) ? vals[idx] : 32'h0;
      #1;
      if (ov[k] && ordy[k]) begin
        if (ng < 16) got[ng] = dout[k];
        ng++;
      end
      if (iv[k] && ir[k]) idx++;
    end
    iv[k]   = 1'b0;
    ordy[k] = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (dout[k] !== 32'h0) begin
        n_fail++; $display("FAIL reset_dout[%0d]: got %h expected 00000000", k, dout[k]);
      end
      n_checks++;
      if (ov[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, ov[k]);
      end
      n_checks++;
      if (ir[k] !== 1'b1) begin
        n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, ir[k]);
      end
    end
  endtask

  task automatic test_pick_basic();
    logic exp_ov;
    ordy[0] = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_ov = ((i - 1) % 2 == 0);
        n_checks++;
        if (ov[0] !== exp_ov) begin
          n_fail++; $display("FAIL pick_r2_valid step %0d: got %b expected %b", i, ov[0], exp_ov);
        end
        if (exp_ov) begin
          n_checks++;
          if (dout[0] !== 32'(10 + i - 1)) begin
            n_fail++; $display("FAIL pick_r2_data step %0d: got %0d expected %0d", i, dout[0], 10 + i - 1);
          end
        end
      end
      n_checks++;
      if (ir[0] !== 1'b1) begin
        n_fail++; $display("FAIL pick_r2_in_ready step %0d: got %b expected 1", i, ir[0]);
      end
      din[0] = 32'(10 + i);
      iv[0]  = (i < 6);
    end
    iv[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] got [16];
    logic [31:0] exp_v [3];
    int ng, idx, stall;
    bit seen;
    exp_v[0] = 32'd3; exp_v[1] = 32'd6; exp_v[2] = 32'd9;
    ng = 0; idx = 0; stall = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ov[1] && !seen) begin seen = 1'b1; stall = 3; end
      ordy[1] = (stall == 0);
      iv[1]   = (idx < 9);
      din[1]  = 32'(idx + 1);
      #1;
      if (stall > 0) begin
        n_checks++;
        if (ir[1] !== 1'b0) begin
          n_fail++; $display("FAIL stall_in_ready cycle %0d: got %b expected 0", c, ir[1]);
        end
        n_checks++;
        if (ov[1] !== 1'b1 || dout[1] !== 32'd3) begin
          n_fail++; $display("FAIL stall_hold cycle %0d: got valid %b data %0d expected 1 / 3", c, ov[1], dout[1]);
        end
        stall--;
      end
      if (ov[1] && ordy[1]) begin
        if (ng < 16) got[ng] = dout[1];
        ng++;
      end
      if (iv[1] && ir[1]) idx++;
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    n_checks++;
    if (ng !== 3) begin
      n_fail++; $display("FAIL stall_count: got %0d outputs expected 3", ng);
    end
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (got[j] !== exp_v[j]) begin
        n_fail++; $display("FAIL stall_data[%0d]: got %0d expected %0d", j, got[j], exp_v[j]);
      end
    end
  endtask

  task automatic test_acc_basic();
    logic [31:0] v [16];
    logic [31:0] got [16];
    int ng;
    for (int j = 0; j < 16; j++) v[j] = '0;
    v[0] = 32'd4; v[1] = 32'd8; v[2] = 32'd12; v[3] = 32'd16;
    v[4] = -32'sd4; v[5] = -32'sd4; v[6] = -32'sd4; v[7] = -32'sd4;
    drive_stream(2, v, 8, 1'b0, got, ng);
    n_checks++;
    if (ng !== 2) begin
      n_fail++; $display("FAIL acc_r4_count: got %0d expected 2", ng);
    end
    n_checks++;
    if (got[0] !== 32'd10) begin
      n_fail++; $display("FAIL acc_r4_first: got %h expected 0000000a", got[0]);
    end
    n_checks++;
    if (got[1] !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL acc_r4_second: got %h expected fffffffc", got[1]);
    end
  endtask

  task automatic test_acc_saturate();
    logic [31:0] v [16];
    logic [31:0] got [16];
    logic [31:0] exp_v [3];
    int ng;
    for (int j = 0; j < 16; j++) v[j] = '0;
    v[0] = 32'h7FFF_FFFF; v[1] = 32'h7FFF_FFFF;
    v[2] = 32'h8000_0000; v[3] = 32'h8000_0000;
    v[4] = 32'd3;         v[5] = -32'sd5;
    exp_v[0] = 32'h7FFF_FFFF; exp_v[1] = 32'h8000_0000; exp_v[2] = 32'hFFFF_FFFE;
    drive_stream(3, v, 6, 1'b0, got, ng);
    n_checks++;
    if (ng !== 3) begin
      n_fail++; $display("FAIL sat_count: got %0d expected 3", ng);
    end
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (got[j] !== exp_v[j]) begin
        n_fail++; $display("FAIL sat_data[%0d]: got %h expected %h", j, got[j], exp_v[j]);
      end
    end
  endtask

  task automatic test_clr_and_reset();
    ordy[4] = 1'b1; clr_s[4] = 1'b0;
    // plain flush after two accepts
    @(negedge clk); din[4] = 32'd100; iv[4] = 1'b1;
    @(negedge clk); din[4] = 32'd101;
    @(negedge clk); iv[4] = 1'b0; clr_s[4] = 1'b1;
    @(negedge clk); clr_s[4] = 1'b0; din[4] = 32'd200; iv[4] = 1'b1;
    @(negedge clk); din[4] = 32'd201;
    @(negedge clk); din[4] = 32'd202;
    @(negedge clk); din[4] = 32'd203;
    n_checks++;
    if (ov[4] !== 1'b0) begin
      n_fail++; $display("FAIL clr_no_early_output: got valid %b data %0d expected 0", ov[4], dout[4]);
    end
    @(negedge clk); iv[4] = 1'b0; ordy[4] = 1'b0;
    n_checks++;
    if (ov[4] !== 1'b1 || dout[4] !== 32'd203) begin
      n_fail++; $display("FAIL clr_realign: got valid %b data %0d expected 1 / 203", ov[4], dout[4]);
    end
    clr_s[4] = 1'b1;
    @(negedge clk); clr_s[4] = 1'b0;
    n_checks++;
    if (ov[4] !== 1'b1 || dout[4] !== 32'd203) begin
      n_fail++; $display("FAIL clr_keeps_output: got valid %b data %0d expected 1 / 203", ov[4], dout[4]);
    end
    // flush on the accept that would have produced an output
    ordy[4] = 1'b1; din[4] = 32'd500; iv[4] = 1'b1;
    @(negedge clk); din[4] = 32'd501;
    @(negedge clk); din[4] = 32'd502;
    @(negedge clk); din[4] = 32'd550; clr_s[4] = 1'b1;
    @(negedge clk); clr_s[4] = 1'b0; iv[4] = 1'b0;
    n_checks++;
    if (ov[4] !== 1'b0 || dout[4] !== 32'd203) begin
      n_fail++; $display("FAIL clr_wins: got valid %b data %0d expected 0 / 203", ov[4], dout[4]);
    end
    // mid-stream reset after two accepts
    din[4] = 32'd300; iv[4] = 1'b1;
    @(negedge clk); din[4] = 32'd301;
    @(negedge clk); iv[4] = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (dout[4] !== 32'h0 || ov[4] !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got valid %b data %0d expected 0 / 0", ov[4], dout[4]);
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din[4] = 32'(400 + i); iv[4] = 1'b1;
      if (i == 3) begin
        n_checks++;
        if (ov[4] !== 1'b0) begin
          n_fail++; $display("FAIL reset_realign_early: got valid %b data %0d expected 0", ov[4], dout[4]);
        end
      end
    end
    @(negedge clk); iv[4] = 1'b0;
    n_checks++;
    if (ov[4] !== 1'b1 || dout[4] !== 32'd403) begin
      n_fail++; $display("FAIL reset_realign: got valid %b data %0d expected 1 / 403", ov[4], dout[4]);
    end
  endtask

  task automatic test_r1_toggle();
    logic [31:0] v [16];
    logic [31:0] got [16];
    int ng;
    for (int j = 0; j < 16; j++) v[j] = '0;
    v[0] = 32'd5; v[1] = -32'sd7; v[2] = 32'd9; v[3] = -32'sd11;
    for (int k = 5; k <= 6; k++) begin
      drive_stream(k, v, 4, 1'b1, got, ng);
      n_checks++;
      if (ng !== 4) begin
        n_fail++; $display("FAIL r1_count inst %0d: got %0d expected 4", k, ng);
      end
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (got[j] !== v[j]) begin
          n_fail++; $display("FAIL r1_data inst %0d [%0d]: got %h expected %h", k, j, got[j], v[j]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 7; k++) begin
      din[k] = '0; iv[k] = 1'b0; ordy[k] = 1'b1; clr_s[k] = 1'b0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    test_reset();
    @(negedge clk); rst = 1'b1;
    test_pick_basic();
    test_backpressure();
    test_acc_basic();
    test_acc_saturate();
    test_clr_and_reset();
    test_r1_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
